// File: rtl/ball_step_sched.sv
// Ball step scheduler: emits step_tick at a level-dependent period and runs the serve/rally/point flow.
// Optional build macro BALL_STEP_KEEP_LEVEL_EN: when defined, the speed level survives a point and only rst clears it.
module ball_step_sched #(
    parameter int BASE_PERIOD    = 50000000,
    parameter int STEP_DEC       = 5000000,
    parameter int NUM_LEVELS     = 8,
    parameter int HITS_PER_LEVEL = 3,
    parameter int SERVE_STEPS    = 2,
    parameter int CNT_W          = 27
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       start,
    input  logic       hit,
    input  logic       miss,
    input  logic       pause,
    output logic       step_tick,
    output logic [2:0] level,
    output logic [1:0] state,
    output logic [7:0] rally_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_RALLY = 2'd2,
        ST_POINT = 2'd3
    } state_t;

    localparam logic [2:0]       LEVEL_MAX  = 3'(NUM_LEVELS - 1);
    localparam logic [7:0]       HITS_TGT   = 8'(HITS_PER_LEVEL);
    localparam logic [7:0]       SERVE_LAST = 8'(SERVE_STEPS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    function automatic logic [CNT_W-1:0] period_of(input logic [2:0] lvl);
        period_of = CNT_W'(BASE_PERIOD) - (CNT_W'(lvl) * CNT_W'(STEP_DEC));
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [2:0]       level_q, level_d;
    logic [7:0]       hits_q, hits_d;
    logic [7:0]       rally_q, rally_d;
    logic [7:0]       serve_q, serve_d;
    logic             step_tick_q, step_tick_d;
    logic             wrap_s;

    assign wrap_s = (cnt_q == (period_q - CNT_ONE));

    // Next-state logic: sequencing, period counter, hit/level bookkeeping.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        period_d    = period_q;
        level_d     = level_q;
        hits_d      = hits_q;
        rally_d     = rally_q;
        serve_d     = serve_q;
        step_tick_d = 1'b0;

        if (pause) begin
            // Everything freezes; the held count resumes on release.
            step_tick_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d   = '0;
                    serve_d = 8'd0;
                    if (start) begin
                        state_d  = ST_SERVE;
                        period_d = period_of(level_q);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SERVE: begin
                    if (miss) begin
                        state_d = ST_POINT;
                        cnt_d   = '0;
                    end else if (wrap_s) begin
                        cnt_d = '0;
                        if (serve_q == SERVE_LAST) begin
                            state_d  = ST_RALLY;
                            serve_d  = 8'd0;
                            period_d = period_of(level_q);
                        end else begin
                            serve_d = serve_q + 8'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_RALLY: begin
                    if (miss) begin
                        // miss wins over a simultaneous hit
                        state_d = ST_POINT;
                        cnt_d   = '0;
                    end else begin
                        if (hit) begin
                            rally_d = (rally_q == 8'd255) ? rally_q : rally_q + 8'd1;
                            if ((hits_q + 8'd1) == HITS_TGT) begin
                                hits_d  = 8'd0;
                                level_d = (level_q == LEVEL_MAX) ? level_q : level_q + 3'd1;
                            end else begin
                                hits_d = hits_q + 8'd1;
                            end
                        end else begin
                            hits_d = hits_q;
                        end
                        if (wrap_s) begin
                            // New period only takes effect at a step boundary.
                            cnt_d       = '0;
                            period_d    = period_of(level_d);
                            step_tick_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                ST_POINT: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    rally_d = 8'd0;
                    hits_d  = 8'd0;
`ifdef BALL_STEP_KEEP_LEVEL_EN
                    level_d = level_q;
`else
                    level_d = 3'd0;
`endif
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            period_q    <= '0;
            level_q     <= 3'd0;
            hits_q      <= 8'd0;
            rally_q     <= 8'd0;
            serve_q     <= 8'd0;
            step_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            level_q     <= level_d;
            hits_q      <= hits_d;
            rally_q     <= rally_d;
            serve_q     <= serve_d;
            step_tick_q <= step_tick_d;
        end
    end

    assign step_tick = step_tick_q;
    assign level     = level_q;
    assign state     = state_q;
    assign rally_cnt = rally_q;

endmodule

// File: doc/ball_step_sched.md
Name: ball_step_sched

Overview:
- Schedules ball motion for the tennis game: emits a one-cycle step_tick enable at a period set by the current speed level.
- Sequences the serve/rally/point flow and raises the speed level as the rally grows.
- Sits between the paddle/collision logic (hit, miss, start) and the ball position updater, which advances one step per step_tick.

Parameters:
- BASE_PERIOD, 50000000, clk_in cycles per ball step at level 0.
- STEP_DEC, 5000000, period reduction per speed level.
- NUM_LEVELS, 8, number of speed levels (0..NUM_LEVELS-1).
- HITS_PER_LEVEL, 3, consecutive rally hits needed to raise the level by one.
- SERVE_STEPS, 2, whole level-0 periods spent in SERVE before RALLY.
- CNT_W, 27, period counter width; must hold BASE_PERIOD.

Ports:
- clk_in  in  1  system clock
- rst  in  1  reset
- start  in  1  serve request pulse
- hit  in  1  paddle-hit pulse
- miss  in  1  point-scored pulse
- pause  in  1  level; freezes scheduling while high
- step_tick  out  1  one-cycle ball-step enable
- level  out  3  current speed level
- state  out  2  IDLE=0, SERVE=1, RALLY=2, POINT=3
- rally_cnt  out  8  hits in current rally, saturating

Behaviour:
- Reset: rst is asynchronous and active-high; clock is clk_in. Reset drives state=IDLE, step_tick=0, level=0, rally_cnt=0, and clears the counter, hit counter and latched period.
- Period rule: period(L) = BASE_PERIOD - L*STEP_DEC. Legal configurations satisfy BASE_PERIOD > (NUM_LEVELS-1)*STEP_DEC.
- Latched period: the period is latched on entry to SERVE/RALLY and at each counter wrap. A level change never truncates a step in progress.
- Counter: counts 0..P-1 while in SERVE/RALLY and pause=0. The counter wraps at P-1. In RALLY, step_tick=1 on the wrap cycle only.
- Tick timing: the first RALLY tick occurs exactly P cycles after RALLY entry. In SERVE no ticks are emitted.
- IDLE: counter held at 0. start -> SERVE on the next edge, with counter=0 and period(level). hit and miss are ignored.
- SERVE: after SERVE_STEPS wraps -> RALLY, with counter reset to 0. miss -> POINT. hit ignored.
- RALLY: hit increments rally_cnt (saturates at 255) and the hit counter.
  - When the hit counter reaches HITS_PER_LEVEL, it clears and level increments, saturating at NUM_LEVELS-1.
  - miss -> POINT.
- POINT: lasts one cycle with step_tick=0. It clears rally_cnt and the hit counter, clears level to 0, then -> IDLE.
- Simultaneous events: if hit and miss arrive in the same cycle, miss wins and hit is discarded. start outside IDLE is ignored.
- pause=1: counter, state and all outputs hold, step_tick=0, and hit/miss/start are ignored. On release, counting resumes from the held value, so the tick is delayed by exactly the pause length.
- Mid-operation rst: immediate return to reset values, including during a tick cycle.

Optional Feature:
- Macro: BALL_STEP_KEEP_LEVEL_EN.
- Defined: POINT does not clear level; level persists across points and only rst clears it. rally_cnt and the hit counter still clear.
- Undefined: POINT clears level to 0 as described above.

Test Plan:
(All scenarios use BASE_PERIOD=10, STEP_DEC=2, NUM_LEVELS=4, HITS_PER_LEVEL=2, SERVE_STEPS=1.)
- Reset then 100 idle cycles -> state=0, level=0, rally_cnt=0, step_tick never asserted.
- start pulse -> state=1 for 10 cycles with no tick, then state=2. First step_tick 10 cycles after RALLY entry, then every 10 cycles.
- 2 hits mid-step -> level=1, rally_cnt=2. Current step still completes at 10 cycles, following steps every 8. 6 total hits -> level=3, period 4. 8th hit -> level stays 3, rally_cnt=8.
- hit and miss in same RALLY cycle -> rally_cnt unchanged, state 3 for one cycle, then 0, with level=0 and rally_cnt=0. With BALL_STEP_KEEP_LEVEL_EN defined, level keeps its pre-point value.
- pause high 7 cycles, starting 3 cycles into a 10-cycle step -> tick occurs 17 cycles after step start. A hit during pause is ignored.
- rst pulsed at level 2 during a step_tick cycle -> step_tick=0 immediately; state=0, level=0, rally_cnt=0 before the next edge.
